// File: rtl/intc_pkg.sv
// Shared types and helpers for the interrupt controller.
// The INTC_TIMEOUT_EN build option is handled in interrupt_controller.sv.
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_ACK = 2'd2,
    HOLDOFF  = 2'd3
  } intc_state_t;

  // Wide enough for PULSE_LEN, HOLDOFF_LEN and TIMEOUT_CYC terminal counts.
  localparam int CNT_W = 16;

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/intc_priority_encoder.sv
// Lowest-index-wins priority encoder over the enabled pending requests.
module intc_priority_encoder
  import intc_pkg::*;
#(
  parameter int NUM_SRC = 4,
  localparam int IW = id_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [IW-1:0]      id,
  output logic               valid
);

  always_comb begin
    id    = '0;
    valid = |req;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = IW'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Multi-source interrupt controller: edge-detect, pending/mask, priority select,
// fixed-width INTERRUPT pulse and ACK hold-off. Define INTC_TIMEOUT_EN for ACK timeout re-issue.
//   state    | meaning
//   IDLE     | waiting for an enabled pending source
//   PULSE    | INTERRUPT high for PULSE_LEN cycles
//   WAIT_ACK | waiting for the ISR to read SRC_ID
//   HOLDOFF  | HOLDOFF_LEN quiet cycles before the next issue
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int PULSE_LEN   = 2,
  parameter int HOLDOFF_LEN = 4,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IW = id_width(NUM_SRC)
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  input  logic               MASK_WE,
  input  logic [NUM_SRC-1:0] MASK_IN,
  input  logic               ACK,
  output logic               INTERRUPT,
  output logic [IW-1:0]      SRC_ID,
  output logic [NUM_SRC-1:0] PENDING,
  output logic [NUM_SRC-1:0] MASK,
`ifdef INTC_TIMEOUT_EN
  output logic               TIMEOUT_FLAG,
`endif
  output logic               BUSY
);

  localparam logic [CNT_W-1:0] PULSE_TC = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'((HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0);
  // With no hold-off configured an accepted ACK returns straight to IDLE.
  localparam intc_state_t AFTER_ACK = (HOLDOFF_LEN > 0) ? HOLDOFF : IDLE;
`ifdef INTC_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_TC = CNT_W'(TIMEOUT_CYC - 1);
`endif

  intc_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SRC-1:0] irq_q, rise, pend_q, mask_q, clr;
  logic [IW-1:0]      id_q, enc_id;
  logic               enc_valid, load_id, ack_take;
`ifdef INTC_TIMEOUT_EN
  logic               to_set, to_flag_q;
`endif

  assign rise = IRQ_IN & ~irq_q;
  assign clr  = ack_take ? (NUM_SRC'(1) << id_q) : '0;

  intc_priority_encoder #(.NUM_SRC(NUM_SRC)) u_prio (
    .req   (pend_q & mask_q),
    .id    (enc_id),
    .valid (enc_valid)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_id  = 1'b0;
    ack_take = 1'b0;
`ifdef INTC_TIMEOUT_EN
    to_set   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          load_id = 1'b1;
          cnt_d   = '0;
          state_d = PULSE;
        end
      end
      PULSE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ACK) begin
          ack_take = 1'b1;
          cnt_d    = '0;
          state_d  = AFTER_ACK;
        end else if (cnt_q == PULSE_TC) begin
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ACK) begin
          ack_take = 1'b1;
          cnt_d    = '0;
          state_d  = AFTER_ACK;
        end
`ifdef INTC_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == TO_TC) begin
            cnt_d   = '0;
            to_set  = 1'b1;
            state_d = PULSE;
          end
        end
`endif
      end
      HOLDOFF: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HOLD_TC) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge on the bit being cleared wins over the clear.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      irq_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      id_q    <= '0;
`ifdef INTC_TIMEOUT_EN
      to_flag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_q   <= IRQ_IN;
      pend_q  <= (pend_q & ~clr) | rise;
      if (MASK_WE) mask_q <= MASK_IN;
      if (load_id) id_q <= enc_id;
`ifdef INTC_TIMEOUT_EN
      if (ack_take)    to_flag_q <= 1'b0;
      else if (to_set) to_flag_q <= 1'b1;
`endif
    end
  end

  assign INTERRUPT = (state_q == PULSE);
  assign BUSY      = (state_q != IDLE);
  assign SRC_ID    = id_q;
  assign PENDING   = pend_q;
  assign MASK      = mask_q;
`ifdef INTC_TIMEOUT_EN
  assign TIMEOUT_FLAG = to_flag_q;
`endif

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: stimulus queues expected SRC_IDs,
// a monitor checks each INTERRUPT pulse's ID and width.
module tb_interrupt_controller;
  import intc_pkg::*;

  localparam int N  = 4;
  localparam int PL = 2;
  localparam int HL = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  IRQ_IN = '0;
  logic          MASK_WE = 1'b0;
  logic [N-1:0]  MASK_IN = '0;
  logic          ACK = 1'b0;
  logic          INTERRUPT, BUSY;
  logic [IW-1:0] SRC_ID;
  logic [N-1:0]  PENDING, MASK;
`ifdef INTC_TIMEOUT_EN
  logic          TIMEOUT_FLAG;
`endif

  interrupt_controller #(
    .NUM_SRC(N), .PULSE_LEN(PL), .HOLDOFF_LEN(HL), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .RST(RST), .IRQ_IN(IRQ_IN), .MASK_WE(MASK_WE), .MASK_IN(MASK_IN),
    .ACK(ACK), .INTERRUPT(INTERRUPT), .SRC_ID(SRC_ID), .PENDING(PENDING),
    .MASK(MASK),
`ifdef INTC_TIMEOUT_EN
    .TIMEOUT_FLAG(TIMEOUT_FLAG),
`endif
    .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [IW-1:0] exp_q[$];

  logic          mon_prev = 1'b0;
  int            mon_len = 0;
  bit            mon_abort = 1'b0;
  logic [IW-1:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [N-1:0] v);
    MASK_IN = v;
    MASK_WE = 1'b1;
    tick();
    MASK_WE = 1'b0;
  endtask

  task automatic pulse_ack();
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
  endtask

  task automatic wait_pulse(input string name);
    int k;
    k = 0;
    while (!INTERRUPT && k < 40) begin tick(); k++; end
    check({name, "_start"}, INTERRUPT, 1);
    k = 0;
    while (INTERRUPT && k < 40) begin tick(); k++; end
    check({name, "_end"}, INTERRUPT, 0);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (BUSY && k < 40) begin tick(); k++; end
    check({name, "_idle"}, BUSY, 0);
  endtask

  // Monitor: every INTERRUPT rise consumes one expected SRC_ID; each complete pulse must be PL wide.
  initial begin
    forever begin
      @(negedge clk);
      if (RST && INTERRUPT) mon_abort = 1'b1;
      if (INTERRUPT && !mon_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue: got SRC_ID %0d expected no issue", SRC_ID);
        end else begin
          mon_exp = exp_q.pop_front();
          if (SRC_ID !== mon_exp) begin
            errors++;
            $display("FAIL src_id: got %0d expected %0d", SRC_ID, mon_exp);
          end
        end
        mon_len = 0;
      end
      if (INTERRUPT) mon_len++;
      if (!INTERRUPT && mon_prev) begin
        if (!mon_abort) begin
          checks++;
          if (mon_len != PL) begin
            errors++;
            $display("FAIL pulse_len: got %0d expected %0d", mon_len, PL);
          end
        end
        mon_abort = 1'b0;
      end
      mon_prev = INTERRUPT;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset
    tick(2);
    RST = 1'b0;
    tick();
    check("rst_interrupt", INTERRUPT, 0);
    check("rst_pending", PENDING, 0);
    check("rst_mask", MASK, 0);
    check("rst_busy", BUSY, 0);

    // Basic issue with exact latency and hold-off
    write_mask(4'b0001);
    check("mask_write", MASK, 4'b0001);
    exp_q.push_back(2'd0);
    IRQ_IN = 4'b0001;
    tick();
    check("basic_pending_k", PENDING, 4'b0001);
    check("basic_int_k", INTERRUPT, 0);
    tick();
    check("basic_int_k1", INTERRUPT, 1);
    check("basic_busy_k1", BUSY, 1);
    tick();
    check("basic_int_k2", INTERRUPT, 1);
    tick();
    check("basic_int_k3", INTERRUPT, 0);
    check("basic_busy_wait", BUSY, 1);
    pulse_ack();
    check("basic_pending_ack", PENDING, 4'b0000);
    check("basic_busy_ack", BUSY, 1);
    tick(3);
    check("basic_busy_hold", BUSY, 1);
    tick();
    check("basic_busy_done", BUSY, 0);
    IRQ_IN = '0;
    tick();

    // Priority: sources 1 and 3 together
    write_mask(4'b1111);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    IRQ_IN = 4'b1010;
    tick();
    wait_pulse("prio1");
    pulse_ack();
    check("prio_pending_mid", PENDING, 4'b1000);
    wait_pulse("prio2");
    pulse_ack();
    wait_idle("prio");
    check("prio_pending_end", PENDING, 4'b0000);
    IRQ_IN = '0;
    tick();

    // Masked pending source issues once unmasked
    write_mask(4'b0000);
    IRQ_IN = 4'b0100;
    tick(4);
    check("mask_hold_pending", PENDING, 4'b0100);
    check("mask_hold_int", INTERRUPT, 0);
    check("mask_hold_busy", BUSY, 0);
    exp_q.push_back(2'd2);
    write_mask(4'b0100);
    tick();
    check("unmask_int", INTERRUPT, 1);
    wait_pulse("unmask");
    pulse_ack();
    wait_idle("unmask");
    IRQ_IN = '0;
    tick();

    // Set/clear collision on source 0
    write_mask(4'b0001);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
    IRQ_IN = 4'b0001;
    tick();
    wait_pulse("coll1");
    IRQ_IN = 4'b0000;
    tick();
    IRQ_IN = 4'b0001;
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    check("coll_pending", PENDING, 4'b0001);
    check("coll_busy", BUSY, 1);
    wait_pulse("coll2");
    pulse_ack();
    wait_idle("coll");
    check("coll_pending_end", PENDING, 4'b0000);
    IRQ_IN = '0;
    tick();

    // Reset during PULSE, line still high at release counts as an edge
    write_mask(4'b1000);
    exp_q.push_back(2'd3);
    IRQ_IN = 4'b1000;
    tick();
    k = 0;
    while (!INTERRUPT && k < 10) begin tick(); k++; end
    check("rstmid_in_pulse", INTERRUPT, 1);
    RST = 1'b1;
    tick();
    check("rstmid_int", INTERRUPT, 0);
    check("rstmid_pending", PENDING, 0);
    check("rstmid_mask", MASK, 0);
    check("rstmid_busy", BUSY, 0);
    RST = 1'b0;
    tick();
    check("rst_release_edge", PENDING, 4'b1000);
    check("rst_release_int", INTERRUPT, 0);
    IRQ_IN = '0;
    tick();

`ifdef INTC_TIMEOUT_EN
    write_mask(4'b0010);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd1);
    IRQ_IN = 4'b0010;
    tick();
    wait_pulse("to1");
    check("to_flag_before", TIMEOUT_FLAG, 0);
    wait_pulse("to2");
    check("to_flag_set", TIMEOUT_FLAG, 1);
    pulse_ack();
    check("to_flag_clr", TIMEOUT_FLAG, 0);
    wait_idle("to");
    IRQ_IN = '0;
    tick();
`endif

    tick(2);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
